dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder_pkg.sv | 35 +++
 rtl/bram_be.sv | 33 +++
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared core definitions: access-size encodings, timer register offsets, size helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'b00,
        SZ_HALF = 2'b01,
        SZ_WORD = 2'b10,
        SZ_RSVD = 2'b11   // reserved encoding, behaves as a word access
    } size_e;

    // Byte offsets of the timer registers relative to the timer window base.
    localparam logic [3:0] TMR_MTIME_LO = 4'h0;
    localparam logic [3:0] TMR_MTIME_HI = 4'h4;
    localparam logic [3:0] TMR_CMP_LO   = 4'h8;
    localparam logic [3:0] TMR_CMP_HI   = 4'hC;

    // Word-sized access, including the reserved size encoding.
    function automatic logic is_word(input logic [1:0] size);
        return (size != SZ_BYTE) && (size != SZ_HALF);
    endfunction

    // Halves need bit 0 clear, words need both low bits clear; bytes are never misaligned.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] a_lo);
        logic mis;
        mis = 1'b0;
        if (size == SZ_HALF)
            mis = a_lo[0];
        else if (is_word(size))
            mis = (a_lo != 2'b00);
        return mis;
    endfunction

endpackage

// File: rtl/bram_be.sv
// Single-port 32-bit RAM with per-byte write enables and a registered read port.
// Latency: read data appears one cycle after an enabled non-write access.
// Backpressure: none; accepts one access per cycle, contents are not reset.
module bram_be #(
    parameter int DEPTH = 1024,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en,
    input  logic [3:0]    we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    // Byte-lane writes, and registered read when the access is a pure read.
    always_ff @(posedge clk) begin
        if (en) begin
            for (int i = 0; i < 4; i++) begin
                if (we[i])
                    mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
            if (we == 4'b0000)
                rdata_q <= mem[addr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: byte-enable RAM plus a 64-bit mtime/mtimecmp timer window.
// Latency: load data and misalign/fault pulses one cycle after the request.
// Backpressure: none; one request per cycle, always accepted.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] TIMER_BASE  = 32'hFFFF_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemReqM,
    input  logic        MemWriteM,
    input  logic [1:0]  SizeM,
    input  logic [31:0] AddrM,
    input  logic [31:0] WriteDataM,
    output logic [31:0] ReadDataW,
    output logic        MisalignW,
    output logic        FaultW,
    output logic        TimerIrq
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0] tmr_off;
    logic        ram_hit, tmr_hit, mis, fault, ok;
    logic        ram_ld, ram_st, tmr_ld, tmr_st;
    logic [3:0]  be;
    logic [31:0] wdata_rep, tmr_rd, ram_rdata, ram_word_sh;

    logic [31:0] rd_q, rd_d;
    logic        sel_ram_q, sel_ram_d;
    logic [1:0]  off_q, off_d;
    logic        mis_q, mis_d;
    logic        fault_q, fault_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;

    // Address decode, alignment/fault classification and store lane steering.
    always_comb begin
        tmr_off   = AddrM - TIMER_BASE;
        ram_hit   = {2'b00, AddrM} < (34'(DEPTH_WORDS) << 2);
        tmr_hit   = !ram_hit && (tmr_off[31:4] == 28'd0) && (tmr_off[1:0] == 2'b00);
        mis       = MemReqM && is_misaligned(SizeM, AddrM[1:0]);
        // Sub-word stores into the timer window are refused as faults.
        fault     = MemReqM && !mis &&
                    (!(ram_hit || tmr_hit) || (tmr_hit && MemWriteM && !is_word(SizeM)));
        ok        = MemReqM && !mis && !fault;
        ram_ld    = ok && ram_hit && !MemWriteM;
        ram_st    = ok && ram_hit && MemWriteM;
        tmr_ld    = ok && tmr_hit && !MemWriteM;
        tmr_st    = ok && tmr_hit && MemWriteM;
        be        = 4'b1111;
        wdata_rep = WriteDataM;
        if (SizeM == SZ_BYTE) begin
            be        = 4'(4'b0001 << AddrM[1:0]);
            wdata_rep = {4{WriteDataM[7:0]}};
        end else if (SizeM == SZ_HALF) begin
            be        = AddrM[1] ? 4'b1100 : 4'b0011;
            wdata_rep = {2{WriteDataM[15:0]}};
        end
        tmr_rd = 32'd0;
        case (tmr_off[3:0])
            TMR_MTIME_LO: tmr_rd = mtime_q[31:0];
            TMR_MTIME_HI: tmr_rd = mtime_q[63:32];
            TMR_CMP_LO:   tmr_rd = mtimecmp_q[31:0];
            TMR_CMP_HI:   tmr_rd = mtimecmp_q[63:32];
            default:      tmr_rd = 32'd0;
        endcase
    end

    bram_be #(
        .DEPTH (DEPTH_WORDS),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .en    (ram_ld || ram_st),
        .we    (ram_st ? be : 4'b0000),
        .addr  (AddrM[AW+1:2]),
        .wdata (wdata_rep),
        .rdata (ram_rdata)
    );

    // RAM loads are aligned after the RAM's own read register; other results come from rd_q.
    assign ram_word_sh = ram_rdata >> {off_q, 3'b000};
    assign ReadDataW   = sel_ram_q ? ram_word_sh : rd_q;
    assign MisalignW   = mis_q;
    assign FaultW      = fault_q;
    assign TimerIrq    = (mtime_q >= mtimecmp_q);

    // Response tracking: rd_q snapshots the shifted RAM word once its cycle passes so idle cycles hold it.
    always_comb begin
        sel_ram_d = ram_ld;
        off_d     = AddrM[1:0];
        mis_d     = mis;
        fault_d   = fault;
        rd_d      = rd_q;
        if (MemReqM)
            rd_d = tmr_ld ? tmr_rd : 32'd0;
        else if (sel_ram_q)
            rd_d = ram_word_sh;
    end

    // Free-running mtime; a store to one half replaces it and blocks carry across halves.
    always_comb begin
        mtime_d    = mtime_q + 64'd1;
        mtimecmp_d = mtimecmp_q;
        if (tmr_st) begin
            case (tmr_off[3:0])
                TMR_MTIME_LO: mtime_d = {mtime_q[63:32], WriteDataM};
                TMR_MTIME_HI: mtime_d = {WriteDataM, mtime_q[31:0] + 32'd1};
                TMR_CMP_LO:   mtimecmp_d[31:0]  = WriteDataM;
                TMR_CMP_HI:   mtimecmp_d[63:32] = WriteDataM;
                default:      mtimecmp_d = mtimecmp_q;
            endcase
        end
    end

    // State registers; reset discards any in-flight response and parks the timer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q       <= 32'd0;
            sel_ram_q  <= 1'b0;
            off_q      <= 2'b00;
            mis_q      <= 1'b0;
            fault_q    <= 1'b0;
            mtime_q    <= 64'd0;
            mtimecmp_q <= '1;
        end else begin
            rd_q       <= rd_d;
            sel_ram_q  <= sel_ram_d;
            off_q      <= off_d;
            mis_q      <= mis_d;
            fault_q    <= fault_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: RAM lanes, alignment, faults, timer and reset.
// Latency: each step drives at a falling edge and checks at the next falling edge.
// Backpressure: n/a.
module tb_dmem_responder;

    localparam logic [31:0] TB = 32'hFFFF_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        MemReqM = 1'b0;
    logic        MemWriteM = 1'b0;
    logic [1:0]  SizeM = 2'b00;
    logic [31:0] AddrM = 32'd0;
    logic [31:0] WriteDataM = 32'd0;
    logic [31:0] ReadDataW;
    logic        MisalignW, FaultW, TimerIrq;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_responder #(.DEPTH_WORDS(1024), .TIMER_BASE(TB)) dut (
        .clk        (clk),
        .reset      (reset),
        .MemReqM    (MemReqM),
        .MemWriteM  (MemWriteM),
        .SizeM      (SizeM),
        .AddrM      (AddrM),
        .WriteDataM (WriteDataM),
        .ReadDataW  (ReadDataW),
        .MisalignW  (MisalignW),
        .FaultW     (FaultW),
        .TimerIrq   (TimerIrq)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input logic req, input logic we, input logic [1:0] sz,
                        input logic [31:0] a, input logic [31:0] wd);
        MemReqM    = req;
        MemWriteM  = we;
        SizeM      = sz;
        AddrM      = a;
        WriteDataM = wd;
        @(negedge clk);
    endtask

    task automatic ld(input logic [1:0] sz, input logic [31:0] a);
        step(1'b1, 1'b0, sz, a, 32'd0);
    endtask

    task automatic st(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
        step(1'b1, 1'b1, sz, a, wd);
    endtask

    task automatic idle();
        step(1'b0, 1'b0, 2'b00, 32'd0, 32'd0);
    endtask

    task automatic flags(input string tag, input logic m, input logic f);
        chk({tag, "_mis"}, {31'd0, MisalignW}, {31'd0, m});
        chk({tag, "_flt"}, {31'd0, FaultW}, {31'd0, f});
    endtask

    initial begin
        // Reset held with a misaligned load pending at the inputs.
        ld(2'b10, 32'h6);
        repeat (3) @(negedge clk);
        chk("rst_rdata", ReadDataW, 32'd0);
        flags("rst", 1'b0, 1'b0);
        chk("rst_irq", {31'd0, TimerIrq}, 32'd0);

        // Release together with an mtime load: the pre-increment value is 0.
        reset = 1'b1;
        ld(2'b10, TB + 32'h0);
        chk("mtime_after_rst", ReadDataW, 32'd0);
        flags("rel", 1'b0, 1'b0);
        ld(2'b10, TB + 32'h8);
        chk("cmp_lo_rst", ReadDataW, 32'hFFFF_FFFF);

        // Word store then sub-word loads of the same word.
        st(2'b10, 32'h10, 32'hDEAD_BEEF);
        chk("st_rdata_zero", ReadDataW, 32'd0);
        flags("st", 1'b0, 1'b0);
        ld(2'b00, 32'h13);
        chk("ld_b13", ReadDataW, 32'h0000_00DE);
        flags("ld_b13", 1'b0, 1'b0);
        ld(2'b00, 32'h11);
        chk("ld_b11", ReadDataW, 32'h00DE_ADBE);
        ld(2'b01, 32'h12);
        chk("ld_h12", ReadDataW, 32'h0000_DEAD);
        ld(2'b10, 32'h10);
        chk("ld_w10", ReadDataW, 32'hDEAD_BEEF);

        // Half and byte stores only touch their lanes.
        st(2'b10, 32'h20, 32'hAAAA_AAAA);
        st(2'b01, 32'h22, 32'hFFFF_1234);
        ld(2'b10, 32'h20);
        chk("ld_half_merge", ReadDataW, 32'h1234_AAAA);
        st(2'b00, 32'h21, 32'h7777_7755);
        ld(2'b10, 32'h20);
        chk("ld_byte_merge", ReadDataW, 32'h1234_55AA);
        idle();
        chk("hold_idle", ReadDataW, 32'h1234_55AA);
        idle();
        chk("hold_idle2", ReadDataW, 32'h1234_55AA);

        // Misaligned accesses: pulse, zero data, no RAM write.
        st(2'b10, 32'h8, 32'h1122_3344);
        ld(2'b10, 32'h6);
        chk("mis_ld_rdata", ReadDataW, 32'd0);
        flags("mis_ld", 1'b1, 1'b0);
        st(2'b01, 32'h9, 32'h0000_BEEF);
        chk("mis_st_rdata", ReadDataW, 32'd0);
        flags("mis_st", 1'b1, 1'b0);
        ld(2'b10, 32'h8);
        chk("mis_ram_kept", ReadDataW, 32'h1122_3344);
        flags("after_mis", 1'b0, 1'b0);

        // Unmapped accesses and RAM upper boundary.
        ld(2'b10, 32'h0001_0000);
        chk("unmap_rdata", ReadDataW, 32'd0);
        flags("unmap", 1'b0, 1'b1);
        idle();
        flags("unmap_pulse", 1'b0, 1'b0);
        ld(2'b10, 32'h0001_0002);
        flags("mis_prio", 1'b1, 1'b0);
        st(2'b00, TB, 32'h0000_0055);
        flags("tmr_byte_st", 1'b0, 1'b1);
        st(2'b10, 32'h0, 32'h0102_0304);
        st(2'b10, 32'hFFC, 32'hCAFE_F00D);
        st(2'b10, 32'h1000, 32'h9999_9999);
        flags("st_1000", 1'b0, 1'b1);
        ld(2'b10, 32'hFFC);
        chk("ld_top", ReadDataW, 32'hCAFE_F00D);
        flags("ld_top", 1'b0, 1'b0);
        ld(2'b10, 32'h0);
        chk("ld_w0_no_alias", ReadDataW, 32'h0102_0304);

        // Timer: compare set to {1,5}, then carry suppression on a high-half write.
        st(2'b10, TB + 32'h8, 32'h5);
        st(2'b10, TB + 32'hC, 32'h1);
        chk("irq_low", {31'd0, TimerIrq}, 32'd0);
        ld(2'b10, TB + 32'hC);
        chk("cmp_hi", ReadDataW, 32'h1);
        st(2'b10, TB + 32'h0, 32'hFFFF_FFFF);
        st(2'b10, TB + 32'h4, 32'h0);
        ld(2'b10, TB + 32'h4);
        chk("no_carry_on_hi_wr", ReadDataW, 32'h0);
        ld(2'b10, TB + 32'h0);
        chk("lo_wrapped", ReadDataW, 32'h1);

        // Natural carry from low into high half, then interrupt at mtime == mtimecmp.
        st(2'b10, TB + 32'h0, 32'hFFFF_FFFE);
        idle();
        chk("irq_pre_wrap", {31'd0, TimerIrq}, 32'd0);
        ld(2'b10, TB + 32'h4);
        chk("hi_before_carry", ReadDataW, 32'h0);
        chk("irq_at_1_0", {31'd0, TimerIrq}, 32'd0);
        ld(2'b10, TB + 32'h4);
        chk("hi_after_carry", ReadDataW, 32'h1);
        ld(2'b10, TB + 32'h0);
        chk("lo_after_carry", ReadDataW, 32'h1);
        idle();
        idle();
        chk("irq_at_1_4", {31'd0, TimerIrq}, 32'd0);
        idle();
        chk("irq_at_1_5", {31'd0, TimerIrq}, 32'd1);

        // Reset asserted while a misaligned load response is showing.
        MemReqM = 1'b1; MemWriteM = 1'b0; SizeM = 2'b10; AddrM = 32'h6;
        @(posedge clk);
        #2;
        flags("pre_rst", 1'b1, 1'b0);
        reset = 1'b0;
        #1;
        chk("rst_mid_rdata", ReadDataW, 32'd0);
        flags("rst_mid", 1'b0, 1'b0);
        chk("rst_mid_irq", {31'd0, TimerIrq}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        ld(2'b10, TB + 32'h0);
        chk("rst2_mtime", ReadDataW, 32'd0);
        flags("rst2_rel", 1'b0, 1'b0);
        ld(2'b10, 32'h10);
        chk("ram_retained", ReadDataW, 32'hDEAD_BEEF);
        idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
